// File: rtl/alu_serial_pkg.sv
// rtl/alu_serial_pkg.sv - ALU op codes and helpers shared by the serial ALU, its slice and benches
//
// Purpose: single home for the ALU_* op codes so the sequencer, the 1-bit
// slice and the testbench agree on encodings.
// Ports: none (package).
package alu_serial_pkg;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_XOR = 3'd7;

  // Carry and overflow only carry meaning for the two arithmetic ops.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_alu1.sv
// rtl/alu_serial_alu1.sv - combinational 1-bit ALU slice (alu1)
//
// Purpose: one bit of the ALU datapath with carry-in/carry-out so slices can
// be chained combinationally or driven bit-serially.
// Ports:
//   a, b      in   operand bits
//   carryin   in   carry into this bit (1 on bit 0 for SUB)
//   control   in   ALU_* op code
//   out       out  result bit
//   carryout  out  carry out of this bit (0 for logic ops)
module alu1
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carryin,
  input  logic [2:0] control,
  output logic       out,
  output logic       carryout
);

  logic b_eff;

  always_comb begin
    // SUB is A + ~B + 1; the +1 arrives as carryin on bit 0.
    b_eff    = (control == ALU_SUB) ? ~b : b;
    out      = 1'b0;
    carryout = 1'b0;
    case (control)
      ALU_ADD, ALU_SUB: begin
        out      = a ^ b_eff ^ carryin;
        carryout = (a & b_eff) | (carryin & (a ^ b_eff));
      end
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_NOR: out = ~(a | b);
      ALU_XOR: out = a ^ b;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// rtl/alu_serial.sv - bit-serial WIDTH-bit ALU sequencer around a single alu1 slice
//
// Purpose: accepts a full-width op on start, feeds one operand bit per clock
// (LSB first) into alu1 with its carry-out registered back to carry-in, and
// reports the collected result and flags with a one-cycle done pulse.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   request, sampled only in IDLE
//   A, B      in   operands, captured on accepted start
//   control   in   ALU_* op code, captured on accepted start
//   busy      out  operation in flight (through the done cycle)
//   done      out  one-cycle completion pulse
//   out       out  result, held until the next completion
//   carryout  out  carry out of the MSB (arith ops only)
//   overflow  out  signed overflow (arith ops only)
//   zero      out  out == 0
//   negative  out  out[WIDTH-1]
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [2:0]       op;
  logic             carry;
  logic             msb_cin;
  logic [CW-1:0]    count;
  logic             slice_out;
  logic             slice_cout;

  alu1 u_alu1 (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carryin  (carry),
    .control  (op),
    .out      (slice_out),
    .carryout (slice_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      op       <= '0;
      carry    <= 1'b0;
      msb_cin  <= 1'b0;
      count    <= '0;
      out      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy stays high through the done cycle, which is spent here.
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            op    <= control;
            carry <= (control == ALU_SUB);
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {slice_out, res[WIDTH-1:1]};
          carry <= slice_cout;
          if (count == LAST) begin
            // carry here is still the carry into the MSB slice.
            msb_cin <= carry;
            count   <= '0;
            state   <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          out      <= res;
          carryout <= is_arith(op) ? carry : 1'b0;
          overflow <= is_arith(op) ? (msb_cin ^ carry) : 1'b0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign zero     = (out == '0);
  assign negative = out[WIDTH-1];

endmodule
